qam_symbol_gen: RTL and testbench

Parametrised PRBS-driven QAM symbol generator for the digital QAM modulation datapath. It produces a test bit stream from a configurable Fibonacci LFSR and groups the bits serial-to-parallel into I/Q symbol words. Each axis is Gray-mapped to signed odd amplitude levels, and 4-, 16- or 64-QAM is selectable at run time. A bit-rate enable `en` replaces a divided clock, so the whole block runs on the system clock.

---
 rtl/qam_symbol_gen_pkg.sv | 48 ++++
 rtl/qam_symbol_gen_if.sv | 28 ++
 rtl/qam_symbol_gen_lfsr.sv | 32 +++
 rtl/qam_symbol_gen.sv | 94 +++++++++
 tb/tb_qam_symbol_gen.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/qam_symbol_gen_pkg.sv
// qam_symbol_gen shared types and helpers.
// Mode encoding, Gray decode and per-axis level mapping.
package qam_pkg;

    typedef enum logic [1:0] {
        QAM4  = 2'd0,
        QAM16 = 2'd1,
        QAM64 = 2'd2
    } qam_mode_e;

    localparam int MAX_M = 3;

    // Reserved mode 3 falls back to QAM-4.
    function automatic logic [2:0] bits_per_axis(
        input logic [1:0] mode
    );
        logic [2:0] m;
        case (mode)
            QAM16:   m = 3'd2;
            QAM64:   m = 3'd3;
            default: m = 3'd1;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] gray2bin(
        input logic [2:0] g
    );
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // level = 2*b - (2^m - 1); always odd and within +/-7.
    function automatic logic signed [7:0] level_map(
        input logic [2:0] code,
        input logic [2:0] m
    );
        logic [7:0] twice_b;
        logic [7:0] offset;
        twice_b = {4'd0, gray2bin(code), 1'b0};
        offset  = (8'd1 << m) - 8'd1;
        return signed'(twice_b - offset);
    endfunction

endpackage

// File: rtl/qam_symbol_gen_if.sv
// Control and symbol bus of the QAM symbol generator.
// master drives the strobes/config, slave is the generator.
interface qam_symbol_gen_if #(
    parameter int LFSR_N = 3,
    parameter int OUT_W  = 4
);
    logic                     en;
    logic [1:0]               mode;
    logic                     seed_ld;
    logic [LFSR_N-1:0]        seed_in;
    logic                     prbs_bit;
    logic [LFSR_N-1:0]        lfsr_state;
    logic                     sym_valid;
    logic signed [OUT_W-1:0]  sym_i;
    logic signed [OUT_W-1:0]  sym_q;

    modport master (
        output en, mode, seed_ld, seed_in,
        input  prbs_bit, lfsr_state,
        input  sym_valid, sym_i, sym_q
    );

    modport slave (
        input  en, mode, seed_ld, seed_in,
        output prbs_bit, lfsr_state,
        output sym_valid, sym_i, sym_q
    );
endinterface

// File: rtl/qam_symbol_gen_lfsr.sv
// Shift-left Fibonacci PRBS register with load.
// A zero load is coerced to 1 and an all-zero state self-recovers.
module prbs_lfsr #(
    parameter int                LFSR_N = 3,
    parameter logic [LFSR_N-1:0] TAPS   = 3'b110,
    parameter logic [LFSR_N-1:0] SEED   = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ld,
    input  logic [LFSR_N-1:0] ld_val,
    output logic [LFSR_N-1:0] state
);
    localparam logic [LFSR_N-1:0] ONE = LFSR_N'(1);

    logic fb;

    assign fb = ^(state & TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (ld) begin
            state <= (ld_val == '0) ? ONE : ld_val;
        end else if (state == '0) begin
            state <= ONE;
        end else if (en) begin
            state <= {state[LFSR_N-2:0], fb};
        end
    end
endmodule

// File: rtl/qam_symbol_gen.sv
// PRBS-driven QAM-4/16/64 symbol generator.
// Collects 2m PRBS bits per symbol and Gray-maps each axis.
module qam_symbol_gen
    import qam_pkg::*;
#(
    parameter int                LFSR_N = 3,
    parameter logic [LFSR_N-1:0] TAPS   = 3'b110,
    parameter logic [LFSR_N-1:0] SEED   = '1,
    parameter int                OUT_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    qam_symbol_gen_if.slave bus
);
    logic [LFSR_N-1:0]       lfsr_q;
    logic [2:0]              cnt;
    logic [5:0]              col;
    logic [1:0]              mode_q;
    logic signed [OUT_W-1:0] sym_i_q;
    logic signed [OUT_W-1:0] sym_q_q;
    logic                    vld_q;

    logic [1:0] mode_use;
    logic [2:0] m;
    logic [3:0] sym_len;
    logic       last;
    logic [5:0] col_nx;
    logic [5:0] mask;
    logic [2:0] i_code;
    logic [2:0] q_code;

    prbs_lfsr #(
        .LFSR_N (LFSR_N),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .ld     (bus.seed_ld),
        .ld_val (bus.seed_in),
        .state  (lfsr_q)
    );

    assign bus.lfsr_state = lfsr_q;
    assign bus.prbs_bit   = lfsr_q[LFSR_N-1];
    assign bus.sym_valid  = vld_q;
    assign bus.sym_i      = sym_i_q;
    assign bus.sym_q      = sym_q_q;

    // The mode in use is the live input only at a symbol boundary.
    always_comb begin
        mode_use = (cnt == 3'd0) ? bus.mode : mode_q;
        m        = bits_per_axis(mode_use);
        sym_len  = {m, 1'b0};
        last     = ({1'b0, cnt} == sym_len - 4'd1);
        col_nx   = {col[4:0], lfsr_q[LFSR_N-1]};
        mask     = (6'd1 << m) - 6'd1;
        i_code   = 3'((col_nx >> m) & mask);
        q_code   = 3'(col_nx & mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            col     <= '0;
            mode_q  <= QAM4;
            sym_i_q <= '0;
            sym_q_q <= '0;
            vld_q   <= 1'b0;
        end else if (bus.seed_ld) begin
            cnt   <= '0;
            col   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (bus.en) begin
                if (cnt == 3'd0) begin
                    mode_q <= bus.mode;
                end
                if (last) begin
                    cnt     <= '0;
                    col     <= '0;
                    sym_i_q <= OUT_W'(level_map(i_code, m));
                    sym_q_q <= OUT_W'(level_map(q_code, m));
                    vld_q   <= 1'b1;
                end else begin
                    cnt <= cnt + 3'd1;
                    col <= col_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_qam_symbol_gen.sv
// Bench for qam_symbol_gen: bit-queue reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_qam_symbol_gen;
    localparam int          N     = 3;
    localparam logic [2:0]  TAPS  = 3'b110;
    localparam logic [2:0]  SEED  = 3'b111;
    localparam int          OUT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qam_symbol_gen_if #(.LFSR_N(N), .OUT_W(OUT_W)) bus ();

    qam_symbol_gen #(
        .LFSR_N (N),
        .TAPS   (TAPS),
        .SEED   (SEED),
        .OUT_W  (OUT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: PRBS state, pending bit queue, output levels.
    logic [2:0] ms   = SEED;
    bit         mbits[$];
    int         mmode = 0;
    int         mi    = 0;
    int         mql   = 0;
    int         mv    = 0;

    function automatic int axis_level(input int start, input int m);
        int g;
        int b;
        g = 0;
        for (int k = 0; k < m; k++) g = g * 2 + int'(mbits[start + k]);
        b = g ^ (g >> 1) ^ (g >> 2);
        return 2 * b - ((1 << m) - 1);
    endfunction

    always @(posedge clk) begin
        int m;
        if (rst) begin
            ms = SEED;
            mbits.delete();
            mmode = 0;
            mi = 0;
            mql = 0;
            mv = 0;
        end else if (bus.seed_ld) begin
            ms = (bus.seed_in == 3'd0) ? 3'd1 : bus.seed_in;
            mbits.delete();
            mv = 0;
        end else begin
            mv = 0;
            if (ms == 3'd0) begin
                ms = 3'd1;
            end else if (bus.en) begin
                if (mbits.size() == 0)
                    mmode = (bus.mode == 2'd3) ? 0 : int'(bus.mode);
                mbits.push_back(ms[N-1]);
                ms = {ms[N-2:0], ^(ms & TAPS)};
                m = mmode + 1;
                if (mbits.size() == 2 * m) begin
                    mi  = axis_level(0, m);
                    mql = axis_level(m, m);
                    mv  = 1;
                    mbits.delete();
                end
            end
        end
    end

    int si_log[$];
    int sq_log[$];

    always @(negedge clk) begin
        if (chk_on) begin
            chk("lfsr_state", int'(bus.lfsr_state), int'(ms));
            chk("prbs_bit", int'(bus.prbs_bit), int'(ms[N-1]));
            chk("sym_valid", int'(bus.sym_valid), mv);
            chk("sym_i", int'($signed(bus.sym_i)), mi);
            chk("sym_q", int'($signed(bus.sym_q)), mql);
            if (bus.sym_valid) begin
                si_log.push_back(int'($signed(bus.sym_i)));
                sq_log.push_back(int'($signed(bus.sym_q)));
            end
        end
    end

    task automatic check_qam4_stream(input string tag);
        int ei[6] = '{1, 1, -1, -1, 1, -1};
        int eq[6] = '{1, -1, 1, 1, 1, -1};
        chk({tag, "_count"}, si_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < si_log.size()) begin
                chk({tag, "_i"}, si_log[k], ei[k]);
                chk({tag, "_q"}, sq_log[k], eq[k]);
            end
        end
    endtask

    initial begin
        int exp_st[7] = '{7, 6, 4, 1, 2, 5, 3};
        int exp_pb[7] = '{1, 1, 1, 0, 0, 1, 0};

        bus.en = 1'b0;
        bus.mode = 2'd0;
        bus.seed_ld = 1'b0;
        bus.seed_in = 3'd0;
        rst = 1'b1;
        cyc(2);
        chk_on = 1'b1;
        chk("reset_lfsr", int'(bus.lfsr_state), 7);
        chk("reset_sym_i", int'($signed(bus.sym_i)), 0);
        chk("reset_valid", int'(bus.sym_valid), 0);

        // PRBS order and QAM-4 symbols from reset.
        rst = 1'b0;
        bus.en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chk("prbs_state_seq", int'(bus.lfsr_state), exp_st[k]);
            chk("prbs_bit_seq", int'(bus.prbs_bit), exp_pb[k]);
            cyc(1);
        end
        cyc(6);
        check_qam4_stream("qam4");

        // QAM-16 with one-cycle en gaps.
        rst = 1'b1;
        bus.en = 1'b0;
        cyc(1);
        rst = 1'b0;
        bus.mode = 2'd1;
        si_log.delete();
        sq_log.delete();
        for (int k = 0; k < 8; k++) begin
            bus.en = 1'b1;
            cyc(1);
            if (k == 3) begin
                chk("qam16_first_valid", int'(bus.sym_valid), 1);
                chk("qam16_first_i", int'($signed(bus.sym_i)), 1);
                chk("qam16_first_q", int'($signed(bus.sym_q)), 3);
            end
            bus.en = 1'b0;
            cyc(1);
        end
        chk("qam16_count", si_log.size(), 2);
        if (si_log.size() == 2) begin
            chk("qam16_second_i", si_log[1], -1);
            chk("qam16_second_q", sq_log[1], -1);
        end

        // QAM-4 -> QAM-64 switch while the counter is 1.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus.mode = 2'd0;
        bus.en = 1'b1;
        si_log.delete();
        sq_log.delete();
        cyc(1);
        bus.mode = 2'd2;
        cyc(8);
        chk("modechg_count", si_log.size(), 2);
        if (si_log.size() == 2) begin
            chk("modechg_qam4_i", si_log[0], 1);
            chk("modechg_qam4_q", sq_log[0], 1);
            chk("modechg_qam64_i", si_log[1], 7);
            chk("modechg_qam64_q", sq_log[1], 5);
        end
        for (int k = 0; k < si_log.size(); k++) begin
            chk("level_range_i",
                (si_log[k] >= -7 && si_log[k] <= 7) ? 1 : 0, 1);
            chk("level_range_q",
                (sq_log[k] >= -7 && sq_log[k] <= 7) ? 1 : 0, 1);
        end

        // Zero seed load mid-symbol, with en also high.
        cyc(1);
        bus.seed_ld = 1'b1;
        bus.seed_in = 3'd0;
        cyc(1);
        bus.seed_ld = 1'b0;
        bus.en = 1'b0;
        chk("seed_zero_coerced", int'(bus.lfsr_state), 1);
        chk("seed_no_valid", int'(bus.sym_valid), 0);
        chk("seed_hold_i", int'($signed(bus.sym_i)), 7);
        chk("seed_hold_q", int'($signed(bus.sym_q)), 5);
        si_log.delete();
        sq_log.delete();
        bus.en = 1'b1;
        cyc(7);
        chk("seed_sym_count", si_log.size(), 1);
        if (si_log.size() >= 1) begin
            chk("seed_sym_i", si_log[0], -5);
            chk("seed_sym_q", sq_log[0], -3);
        end

        // Reset during QAM-64 collection, then restart in QAM-4.
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("midrst_lfsr", int'(bus.lfsr_state), 7);
        chk("midrst_sym_i", int'($signed(bus.sym_i)), 0);
        chk("midrst_sym_q", int'($signed(bus.sym_q)), 0);
        chk("midrst_valid", int'(bus.sym_valid), 0);
        rst = 1'b0;
        bus.mode = 2'd0;
        si_log.delete();
        sq_log.delete();
        cyc(13);
        check_qam4_stream("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
